// File: rtl/job_dispatch.sv
// job_dispatch: queues job requests and drives the go/kill/done worker.
// Each job is launched with a one-cycle go pulse, watched by a watchdog,
// killed and relaunched up to MAX_RETRY times, then reported as ok or fail.
// Optional feature: define JOB_DISPATCH_ABORT_EN to add an abort input that
// kills the running job without retry and flushes the request queue.
module job_dispatch #(
  parameter int TIMEOUT   = 120,
  parameter int KILL_HOLD = 4,
  parameter int MAX_RETRY = 2,
  parameter int QDEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
`ifdef JOB_DISPATCH_ABORT_EN
  input  logic       abort,
`endif
  output logic       req_full,
  output logic       go,
  output logic       kill,
  input  logic       done,
  output logic       busy,
  output logic       job_ok,
  output logic       job_fail,
  output logic [7:0] ok_cnt,
  output logic [7:0] fail_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    KILL,
    BACKOFF
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(KILL_HOLD - 1);
  localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRY);
  localparam logic [3:0] Q_FULL     = 4'(QDEPTH);

  state_t     state;
  state_t     next_state;
  logic [7:0] timer;
  logic [3:0] hold;
  logic [3:0] retry;
  logic [3:0] pending;
  logic       done_q;

  logic       done_rise;
  logic       pop;
  logic       abort_hit;
  logic       clear_q;
  logic       go_next;
  logic       kill_next;
  logic       ok_next;
  logic       fail_next;

`ifdef JOB_DISPATCH_ABORT_EN
  assign abort_hit = abort && ((state == LAUNCH) || (state == WAIT));
  assign clear_q   = abort;
`else
  assign abort_hit = 1'b0;
  assign clear_q   = 1'b0;
`endif

  // Only a fresh rising edge of done counts; a level left high is ignored.
  assign done_rise = done & ~done_q;
  assign pop       = (state == IDLE) && (pending != 4'd0);
  assign req_full  = (pending == Q_FULL);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state selection; a completion beats a simultaneous timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pop) next_state = LAUNCH;
      LAUNCH:  next_state = abort_hit ? KILL : WAIT;
      WAIT: begin
        if (abort_hit)                 next_state = KILL;
        else if (done_rise)            next_state = IDLE;
        else if (timer == TIMER_LAST)  next_state = KILL;
      end
      KILL:    if (hold == HOLD_LAST) next_state = BACKOFF;
      BACKOFF: next_state = (retry < RETRY_MAX) ? LAUNCH : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode, fed into registers so go/kill/job pulses are glitch-free.
  always_comb begin
    go_next   = (next_state == LAUNCH);
    kill_next = (next_state == KILL);
    ok_next   = (state == WAIT) && !abort_hit && done_rise;
    fail_next = (state == BACKOFF) && !(retry < RETRY_MAX);
  end

  // Registered worker controls and result pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go       <= 1'b0;
      kill     <= 1'b0;
      job_ok   <= 1'b0;
      job_fail <= 1'b0;
    end else begin
      go       <= go_next;
      kill     <= kill_next;
      job_ok   <= ok_next;
      job_fail <= fail_next;
    end
  end

  // Watchdog timer, kill-hold counter, retry counter and done edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer  <= 8'd0;
      hold   <= 4'd0;
      retry  <= 4'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= done;
      if (state == LAUNCH)    timer <= 8'd0;
      else if (state == WAIT) timer <= timer + 8'd1;
      if (state == KILL) hold <= hold + 4'd1;
      else               hold <= 4'd0;
      if (pop)
        retry <= 4'd0;
      else if (abort_hit)
        retry <= RETRY_MAX;
      else if ((state == BACKOFF) && (retry < RETRY_MAX))
        retry <= retry + 4'd1;
    end
  end

  // Pending-request counter; a push while full is silently dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 4'd0;
    end else if (clear_q) begin
      pending <= 4'd0;
    end else begin
      case ({req, pop})
        2'b10:   if (!req_full) pending <= pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
    end
  end

  // Saturating success and failure statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ok_cnt   <= 8'd0;
      fail_cnt <= 8'd0;
    end else begin
      if (ok_next && (ok_cnt != 8'hFF))     ok_cnt   <= ok_cnt + 8'd1;
      if (fail_next && (fail_cnt != 8'hFF)) fail_cnt <= fail_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_job_dispatch.sv
// tb_job_dispatch: directed bench for job_dispatch with a per-cycle model.
// The model tracks each job by its age since go rather than by FSM state.
module tb_job_dispatch;

  localparam int TIMEOUT   = 120;
  localparam int KILL_HOLD = 4;
  localparam int MAX_RETRY = 2;
  localparam int QDEPTH    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       done = 1'b0;
  logic       req_full, go, kill, busy, job_ok, job_fail;
  logic [7:0] ok_cnt, fail_cnt;
`ifdef JOB_DISPATCH_ABORT_EN
  logic       abort = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  int go_seen = 0, kill_seen = 0, ok_seen = 0, fail_seen = 0;

  // Model state: job active, age in cycles since its go, attempt index.
  bit m_active = 0, m_ok_pulse = 0, m_fail_pulse = 0, m_prev_done = 0;
  bit m_rise, m_pop;
  int m_age = 0, m_attempt = 0, m_pending = 0, m_ok = 0, m_fail = 0;

  job_dispatch #(
    .TIMEOUT(TIMEOUT), .KILL_HOLD(KILL_HOLD),
    .MAX_RETRY(MAX_RETRY), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
`ifdef JOB_DISPATCH_ABORT_EN
    .abort(abort),
`endif
    .req_full(req_full),
    .go(go),
    .kill(kill),
    .done(done),
    .busy(busy),
    .job_ok(job_ok),
    .job_fail(job_fail),
    .ok_cnt(ok_cnt),
    .fail_cnt(fail_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Behavioural model: a job waits TIMEOUT cycles after go, is killed for
  // KILL_HOLD cycles, rests one cycle, and relaunches while attempts remain.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_ok_pulse = 0; m_fail_pulse = 0; m_prev_done = 0;
      m_age = 0; m_attempt = 0; m_pending = 0; m_ok = 0; m_fail = 0;
    end else begin
      m_rise = done && !m_prev_done;
      m_pop  = !m_active && (m_pending > 0);
      m_ok_pulse = 0;
      m_fail_pulse = 0;
      if (m_active) begin
        if (m_age >= 1 && m_age <= TIMEOUT && m_rise) begin
          m_active = 0;
          m_ok_pulse = 1;
          if (m_ok < 255) m_ok++;
        end else if (m_age == TIMEOUT + KILL_HOLD + 1) begin
          if (m_attempt < MAX_RETRY) begin
            m_attempt++;
            m_age = 0;
          end else begin
            m_active = 0;
            m_fail_pulse = 1;
            if (m_fail < 255) m_fail++;
          end
        end else begin
          m_age++;
        end
      end else if (m_pop) begin
        m_active = 1;
        m_age = 0;
        m_attempt = 0;
      end
      if (req && !m_pop && m_pending < QDEPTH) m_pending++;
      else if (!req && m_pop) m_pending--;
      m_prev_done = done;
    end
  end

  // Compare every output with the model each cycle and tally observed events.
  always @(negedge clk) begin
    cycle++;
    checkOutput("go",       int'(go),       int'(m_active && m_age == 0));
    checkOutput("kill",     int'(kill),     int'(m_active && m_age > TIMEOUT && m_age <= TIMEOUT + KILL_HOLD));
    checkOutput("busy",     int'(busy),     int'(m_active));
    checkOutput("job_ok",   int'(job_ok),   int'(m_ok_pulse));
    checkOutput("job_fail", int'(job_fail), int'(m_fail_pulse));
    checkOutput("req_full", int'(req_full), int'(m_pending == QDEPTH));
    checkOutput("ok_cnt",   int'(ok_cnt),   m_ok);
    checkOutput("fail_cnt", int'(fail_cnt), m_fail);
    if (go)       go_seen++;
    if (kill)     kill_seen++;
    if (job_ok)   ok_seen++;
    if (job_fail) fail_seen++;
  end

  // Raise req for n consecutive cycles, starting at a falling edge.
  task automatic applyStimulus(input int n);
    req = 1'b1;
    repeat (n) @(negedge clk);
    req = 1'b0;
  endtask

  // Wait (bounded) for an event: 0 go, 1 kill high, 2 kill low, 3 job_ok, 4 job_fail.
  task automatic wait_for(input string tag, input int which, input int limit, output int n);
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = go;
        1:       hit = kill;
        2:       hit = !kill;
        3:       hit = job_ok;
        default: hit = job_fail;
      endcase
    end
    if (!hit) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got stalled run, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int n, b_go, b_kill, b_ok;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_ok_cnt", int'(ok_cnt), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_go", int'(go), 0);
    @(negedge clk);

    // Single job completing 100 cycles after go.
    $display("[TB] single job");
    #1 b_go = go_seen; b_kill = kill_seen; b_ok = ok_seen;
    @(negedge clk);
    applyStimulus(1);
    checkOutput("lat_n1_go", int'(go), 0);
    @(negedge clk);
    checkOutput("lat_n2_go", int'(go), 1);
    repeat (100) @(negedge clk);
    done = 1'b1;
    wait_for("single_ok", 3, 5, n);
    checkOutput("single_ok_lat", n, 1);
    done = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("single_ok_cnt", int'(ok_cnt), 1);
    checkOutput("single_busy", int'(busy), 0);
    checkOutput("single_go_n", go_seen - b_go, 1);
    checkOutput("single_kill_n", kill_seen - b_kill, 0);
    checkOutput("single_ok_n", ok_seen - b_ok, 1);

    // Timeout on every attempt, ending in failure.
    $display("[TB] timeout with retries");
    b_go = go_seen; b_kill = kill_seen;
    @(negedge clk);
    applyStimulus(1);
    wait_for("to_go0", 0, 5, n);
    checkOutput("to_launch_lat", n, 1);
    for (int a = 0; a <= MAX_RETRY; a++) begin
      wait_for("to_kill", 1, 200, n);
      checkOutput("to_go_to_kill", n, TIMEOUT + 1);
      wait_for("to_kill_low", 2, 10, n);
      checkOutput("to_kill_width", n, KILL_HOLD);
      if (a < MAX_RETRY) begin
        wait_for("to_rego", 0, 5, n);
        checkOutput("to_backoff_go", n, 1);
      end
    end
    wait_for("to_fail", 4, 5, n);
    checkOutput("to_fail_lat", n, 1);
    #1;
    checkOutput("to_fail_cnt", int'(fail_cnt), 1);
    checkOutput("to_ok_cnt", int'(ok_cnt), 1);
    checkOutput("to_go_n", go_seen - b_go, 3);
    checkOutput("to_kill_n", kill_seen - b_kill, 12);

    // Recovery on the second attempt.
    $display("[TB] recover on retry");
    b_go = go_seen; b_kill = kill_seen;
    @(negedge clk);
    applyStimulus(1);
    wait_for("rc_go0", 0, 5, n);
    wait_for("rc_kill", 1, 200, n);
    checkOutput("rc_go_to_kill", n, TIMEOUT + 1);
    wait_for("rc_kill_low", 2, 10, n);
    wait_for("rc_go1", 0, 5, n);
    repeat (10) @(negedge clk);
    done = 1'b1;
    wait_for("rc_ok", 3, 5, n);
    done = 1'b0;
    #1;
    checkOutput("rc_ok_cnt", int'(ok_cnt), 2);
    checkOutput("rc_fail_cnt", int'(fail_cnt), 1);
    checkOutput("rc_kill_n", kill_seen - b_kill, KILL_HOLD);
    checkOutput("rc_go_n", go_seen - b_go, 2);

    // Six back-to-back requests from idle: one popped, four queued, one dropped.
    $display("[TB] queue full");
    @(negedge clk);
    #1 b_go = go_seen; b_ok = ok_seen;
    @(negedge clk);
    req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 4) checkOutput("q_full_at3", int'(req_full), 0);
      if (i == 5) checkOutput("q_full_at4", int'(req_full), 1);
    end
    req = 1'b0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wait_for("q_go", 0, 20, n);
      repeat (2) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end
    repeat (20) @(negedge clk);
    #1;
    checkOutput("q_go_n", go_seen - b_go, 5);
    checkOutput("q_ok_n", ok_seen - b_ok, 5);
    checkOutput("q_ok_cnt", int'(ok_cnt), 7);
    checkOutput("q_empty", int'(req_full), 0);

    // done rising on the timeout cycle wins; a held level is not a completion.
    $display("[TB] tie and stale done");
    b_kill = kill_seen;
    @(negedge clk);
    applyStimulus(1);
    wait_for("tie_go", 0, 5, n);
    repeat (TIMEOUT) @(negedge clk);
    done = 1'b1;
    wait_for("tie_ok", 3, 5, n);
    checkOutput("tie_ok_lat", n, 1);
    #1;
    checkOutput("tie_no_kill", kill_seen - b_kill, 0);
    b_ok = ok_seen;
    @(negedge clk);
    applyStimulus(1);
    wait_for("stale_go", 0, 5, n);
    repeat (50) @(negedge clk);
    #1;
    checkOutput("stale_no_ok", ok_seen - b_ok, 0);
    done = 1'b0;
    @(negedge clk);
    done = 1'b1;
    wait_for("fresh_ok", 3, 5, n);
    checkOutput("fresh_ok_lat", n, 1);
    done = 1'b0;
    #1;
    checkOutput("fresh_ok_cnt", int'(ok_cnt), 9);

    // Reset while killing with two jobs pending.
    $display("[TB] reset mid-operation");
    @(negedge clk);
    applyStimulus(3);
    wait_for("rm_kill", 1, 200, n);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rm_kill", int'(kill), 0);
    checkOutput("rm_busy", int'(busy), 0);
    checkOutput("rm_ok_cnt", int'(ok_cnt), 0);
    checkOutput("rm_fail_cnt", int'(fail_cnt), 0);
    checkOutput("rm_full", int'(req_full), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 b_go = go_seen;
    repeat (30) @(negedge clk);
    #1;
    checkOutput("rm_no_go", go_seen - b_go, 0);
    @(negedge clk);
    applyStimulus(1);
    @(negedge clk);
    checkOutput("rm_new_go", int'(go), 1);
    repeat (5) @(negedge clk);
    done = 1'b1;
    wait_for("rm_ok", 3, 5, n);
    done = 1'b0;
    #1;
    checkOutput("rm_ok_after", int'(ok_cnt), 1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
